// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder: latches a MSG_LEN-bit message on st, encodes one bit per clock.
// Latency: st sampled at edge k -> done high in the cycle after edge k+MSG_LEN+1; one block per MSG_LEN+2 cycles.
// Backpressure: none; st is only honoured in S_IDLE. Optional serial symbol stream under ENC_SYM_STREAM_EN.
module conv_encoder #(
    parameter int         MSG_LEN = 10,
    parameter logic [2:0] G0      = 3'b111,
    parameter logic [2:0] G1      = 3'b101
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st,
    input  logic [MSG_LEN-1:0]   data_in,
    output logic [2*MSG_LEN-1:0] code_out,
    output logic                 busy,
    output logic                 done
`ifdef ENC_SYM_STREAM_EN
    ,
    output logic [1:0]           sym_out,
    output logic                 sym_valid
`endif
);

    localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(MSG_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [MSG_LEN-1:0]   msg_reg;
    logic [2*MSG_LEN-1:0] code_reg;
    logic [1:0]           trel;      // {s1,s0}, s1 = most recent bit, matches decoder node index
    logic [CW-1:0]        cnt;
    logic                 b;
    logic [1:0]           sym;

    // Current message bit and the two code bits it produces from the trellis state
    always_comb begin
        b      = msg_reg[cnt];
        sym[1] = ^(G0 & {b, trel});
        sym[0] = ^(G1 & {b, trel});
    end

    // Control FSM, trellis state and code word accumulation; busy/done trail the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            trel     <= 2'b00;
            cnt      <= '0;
            msg_reg  <= '0;
            code_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state != S_IDLE);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (st) begin
                        msg_reg <= data_in;
                        trel    <= 2'b00;
                        cnt     <= '0;
                        state   <= S_ENC;
                    end
                end
                S_ENC: begin
                    code_reg[{cnt, 1'b0} +: 2] <= sym;
                    trel <= {b, trel[1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign code_out = code_reg;

`ifdef ENC_SYM_STREAM_EN
    // Serial copy of each symbol as it is written into the code word
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= (state == S_ENC);
            if (state == S_ENC) begin
                sym_out <= sym;
            end
        end
    end
`endif

endmodule
